axi4_m_w_split: RTL and testbench

- AXI4 write master that feeds the co-simulation bridge's AXI4 write slave.
- Accepts one write descriptor (start address, beat count) plus a full-width data stream.
- Emits a sequence of INCR bursts that never cross a 4 KB boundary and never exceed MAXB beats.
- Keeps one burst outstanding at a time, collects the B responses, and reports one completion per descriptor.

---
 rtl/axi4_m_w_split.sv | 144 ++++++++++++++
 tb/tb_axi4_m_w_split.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_m_w_split.sv
// AXI4 write master: splits one descriptor into INCR bursts capped at MAXB beats.
// Bursts never cross a 4 KB boundary. Only one burst is in flight at a time.
module axi4_m_w_split #(
  parameter int TAGW     = 3,
  parameter int ADRW     = 32,
  parameter int DATW     = 256,
  parameter int STBW     = DATW/8,
  parameter int MAXB     = 256,
  parameter int CNTW     = 16,
  parameter int BURST_ID = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [ADRW-1:0] i_req_addr,
  input  logic [CNTW-1:0] i_req_beats,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [DATW-1:0] i_dat_data,
  input  logic [STBW-1:0] i_dat_strb,
  input  logic            i_dat_valid,
  output logic            o_dat_ready,
  output logic [TAGW-1:0] o_m_awid,
  output logic [ADRW-1:0] o_m_awaddr,
  output logic [7:0]      o_m_awlen,
  output logic [2:0]      o_m_awsize,
  output logic [1:0]      o_m_awburst,
  output logic            o_m_awvalid,
  input  logic            i_m_awready,
  output logic [DATW-1:0] o_m_wdata,
  output logic [STBW-1:0] o_m_wstrb,
  output logic            o_m_wlast,
  output logic            o_m_wvalid,
  input  logic            i_m_wready,
  input  logic [TAGW-1:0] i_m_bid,
  input  logic [1:0]      i_m_bresp,
  input  logic            i_m_bvalid,
  output logic            o_m_bready,
  output logic            o_done,
  output logic            o_err
);
  localparam int SZ = $clog2(STBW);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [ADRW-1:0] addr_q, addr_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [7:0]      beat_q, beat_d;
  logic            err_q, err_d;
  logic [8:0]      blen, nb;
  logic            unused_bid;

  // Beats available before the next 4 KB line, clamped by MAXB and what is left.
  function automatic logic [8:0] calc_blen(input logic [ADRW-1:0] a, input logic [CNTW-1:0] r);
    logic [31:0] t, m, rr;
    t  = (32'd4096 - {20'd0, a[11:0]}) >> SZ;
    m  = 32'(MAXB);
    rr = 32'(r);
    if (m < t)  t = m;
    if (rr < t) t = rr;
    return t[8:0];
  endfunction

  assign blen       = {1'b0, awlen_q} + 9'd1;
  assign unused_bid = ^i_m_bid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    awlen_d = awlen_q;
    beat_d  = beat_q;
    err_d   = err_q;
    nb      = 9'd1;
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        addr_d  = i_req_addr;
        rem_d   = i_req_beats;
        err_d   = 1'b0;
        nb      = calc_blen(i_req_addr, i_req_beats);
        awlen_d = 8'(nb - 9'd1);
        state_d = S_AW;
      end
      S_AW: if (i_m_awready) begin
        beat_d  = 8'd0;
        state_d = S_W;
      end
      S_W: if (i_dat_valid && i_m_wready) begin
        beat_d = beat_q + 8'd1;
        if (beat_q == awlen_q) state_d = S_B;
      end
      S_B: if (i_m_bvalid) begin
        err_d  = err_q | (i_m_bresp != 2'b00);
        addr_d = addr_q + (ADRW'(blen) << SZ);
        rem_d  = rem_q - CNTW'(blen);
        if (rem_d != '0) begin
          nb      = calc_blen(addr_d, rem_d);
          awlen_d = 8'(nb - 9'd1);
          state_d = S_AW;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      awlen_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      awlen_q <= awlen_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_m_awid    = TAGW'(BURST_ID);
  assign o_m_awsize  = 3'(SZ);
  assign o_m_awburst = 2'b01;
  assign o_m_awaddr  = addr_q;
  assign o_m_awlen   = awlen_q;
  assign o_m_awvalid = (state_q == S_AW);
  // Data path is a zero-latency pass-through, held at zero outside the data phase.
  assign o_m_wvalid  = (state_q == S_W) & i_dat_valid;
  assign o_dat_ready = (state_q == S_W) & i_m_wready;
  assign o_m_wdata   = (state_q == S_W) ? i_dat_data : '0;
  assign o_m_wstrb   = (state_q == S_W) ? i_dat_strb : '0;
  assign o_m_wlast   = (state_q == S_W) & (beat_q == awlen_q);
  assign o_m_bready  = (state_q == S_B);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = (state_q == S_DONE) & err_q;
endmodule

// File: tb/tb_axi4_m_w_split.sv
// Scoreboard bench for axi4_m_w_split: expected AW/W/done pushed on issue, monitor compares.
module tb_axi4_m_w_split;
  logic         clk, rst;
  logic [31:0]  req_addr;
  logic [15:0]  req_beats;
  logic         req_valid, req_ready;
  logic [255:0] dat_data;
  logic [31:0]  dat_strb;
  logic         dat_valid, dat_ready;
  logic [2:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [2:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic         done, err;

  axi4_m_w_split dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_addr(req_addr), .i_req_beats(req_beats), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_dat_data(dat_data), .i_dat_strb(dat_strb), .i_dat_valid(dat_valid), .o_dat_ready(dat_ready),
    .o_m_awid(awid), .o_m_awaddr(awaddr), .o_m_awlen(awlen), .o_m_awsize(awsize),
    .o_m_awburst(awburst), .o_m_awvalid(awvalid), .i_m_awready(awready),
    .o_m_wdata(wdata), .o_m_wstrb(wstrb), .o_m_wlast(wlast), .o_m_wvalid(wvalid), .i_m_wready(wready),
    .i_m_bid(bid), .i_m_bresp(bresp), .i_m_bvalid(bvalid), .o_m_bready(bready),
    .o_done(done), .o_err(err)
  );

  typedef struct { logic [31:0] a; logic [7:0] l; } aw_t;
  typedef struct { logic [255:0] d; logic [31:0] s; logic last; } w_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  w_t         src[$];
  logic       exp_done[$];
  logic [1:0] bq[$];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   wcnt = 0;
  int   seq = 1;
  logic gaps = 1'b0;
  logic w_hs = 1'b0;
  logic b_hs = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [7:0] l);
    w_t w;
    aw_t x;
    x.a = a; x.l = l;
    exp_aw.push_back(x);
    for (int i = 0; i <= int'(l); i++) begin
      w.d = {8{32'(seq)}};
      w.s = {seq[15:0], ~seq[15:0]};
      w.last = (i == int'(l));
      seq++;
      exp_w.push_back(w);
      src.push_back(w);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic e);
    logic ok;
    ok = 1'b0;
    exp_done.push_back(e);
    @(posedge clk); #1;
    req_addr = a; req_beats = b; req_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("req_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_done.size() == 0) break;
    end
    chk("drain_pending", 64'(exp_aw.size() + exp_w.size() + exp_done.size()), 64'd0);
  endtask

  // Data source: presents the head of src, pops on a handshake seen by the monitor.
  initial begin
    dat_valid = 1'b0; dat_data = '0; dat_strb = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin dat_valid = 1'b0; continue; end
      if (w_hs) begin
        if (src.size() > 0) void'(src.pop_front());
        w_hs = 1'b0;
      end
      if (src.size() == 0 || (gaps && $urandom_range(0, 2) == 0)) dat_valid = 1'b0;
      else begin
        dat_valid = 1'b1; dat_data = src[0].d; dat_strb = src[0].s;
      end
    end
  end

  // Slave model: ready with optional gaps, one B per burst with queued bresp.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 3'd0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin awready = 1'b0; wready = 1'b0; bvalid = 1'b0; continue; end
      if (b_hs) begin
        if (bq.size() > 0) void'(bq.pop_front());
        b_hs = 1'b0;
      end
      awready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = bready;
      bresp   = (bq.size() > 0) ? bq[0] : 2'b00;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else begin
          chk("awaddr", 64'(awaddr), 64'(exp_aw[0].a));
          chk("awlen", 64'(awlen), 64'(exp_aw[0].l));
          chk("aw_const", 64'({awid, awsize, awburst}), 64'({3'd0, 3'd5, 2'b01}));
          void'(exp_aw.pop_front());
        end
      end
      if (wvalid && wready) begin
        w_hs = 1'b1;
        wcnt++;
        total_cnt++;
        if (exp_w.size() == 0) $display("FAIL w_unexpected: got beat %h expected none", wdata);
        else begin
          if (wdata === exp_w[0].d && wstrb === exp_w[0].s && wlast === exp_w[0].last) pass_cnt++;
          else $display("FAIL wbeat: got %h/%h/%b expected %h/%h/%b",
                        wdata, wstrb, wlast, exp_w[0].d, exp_w[0].s, exp_w[0].last);
          void'(exp_w.pop_front());
        end
      end
      if (bready && bvalid) b_hs = 1'b1;
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else chk("done_err", 64'(err), 64'(exp_done.pop_front()));
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_beats = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valids", 64'({awvalid, wvalid, bready, done, err, dat_ready}), 64'd0);
    chk("rst_const", 64'({awid, awsize, awburst}), 64'({3'd0, 3'd5, 2'b01}));
    chk("rst_aw", 64'({awaddr, awlen}), 64'd0);
    rst = 1'b0;

    // single burst
    push_burst(32'h1000, 8'd3);
    issue(32'h1000, 16'd4, 1'b0);
    drain();
    // 4 KB split after two beats
    push_burst(32'h0FC0, 8'd1);
    push_burst(32'h1000, 8'd1);
    issue(32'h0FC0, 16'd4, 1'b0);
    drain();
    // 300 beats: 4 KB lines cap bursts at 128
    push_burst(32'h0000, 8'd127);
    push_burst(32'h1000, 8'd127);
    push_burst(32'h2000, 8'd43);
    issue(32'h0000, 16'd300, 1'b0);
    drain();
    // random stalls on both sides
    gaps = 1'b1;
    push_burst(32'h2000, 8'd7);
    issue(32'h2000, 16'd8, 1'b0);
    drain();
    gaps = 1'b0;
    // error on first burst only
    bq.push_back(2'b10);
    bq.push_back(2'b00);
    push_burst(32'h0FE0, 8'd0);
    push_burst(32'h1000, 8'd0);
    issue(32'h0FE0, 16'd2, 1'b1);
    drain();
    // reset in the middle of a burst
    base = wcnt;
    push_burst(32'h3000, 8'd3);
    issue(32'h3000, 16'd4, 1'b0);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (wcnt >= base + 2) break;
    end
    chk("reset_point_beats", 64'(wcnt - base), 64'd2);
    #2;
    rst = 1'b1;
    dat_valid = 1'b0;
    exp_aw.delete(); exp_w.delete(); src.delete(); exp_done.delete(); bq.delete();
    w_hs = 1'b0; b_hs = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_valids", 64'({awvalid, wvalid, bready, done, dat_ready}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_done", 64'(exp_done.size()), 64'd0);
    push_burst(32'h4000, 8'd2);
    issue(32'h4000, 16'd3, 1'b0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
